x_stream_tx: RTL and testbench
==============================

X_STREAM_TX -- requirements
Module: x_stream_tx

Interface
REQ-001 Parameter T, default 8: sample width in bits.
REQ-002 Parameter N, default 8: samples per vector; AW = clog2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  load strobe for the sample buffer.
REQ-006 wr_addr  input  AW  buffer write index.
REQ-007 wr_data  input  T  sample to store.
REQ-008 start  input  1  request to transmit the buffered vector.
REQ-009 rep_count  input  4  extra repetitions; present only with X_STREAM_TX_REPEAT_EN.
REQ-010 busy  output  1  high while a vector is being transmitted.
REQ-011 done  output  1  one-cycle pulse after the last sample handshake.
REQ-012 m_data_out_x  output  T  stream data, registered.
REQ-013 m_valid_x  output  1  stream valid, registered.
REQ-014 m_ready_x  input  1  downstream ready.

Function
REQ-015 States: IDLE, SEND; the read pointer ptr counts 0..N-1.
REQ-016 IDLE: wr_en with start low writes wr_data to mem[wr_addr] at the clock edge.
REQ-017 SEND: wr_en is ignored and the buffer contents do not change.
REQ-018 IDLE and start sampled high: next cycle state=SEND, busy=1, m_valid_x=1, m_data_out_x=mem[0], ptr=0.
REQ-019 start and wr_en high in the same IDLE cycle: start wins and the write is dropped.
REQ-020 start while in SEND is ignored.
REQ-021 A transfer occurs on a cycle where m_valid_x and m_ready_x are both high.
REQ-022 While m_valid_x=1 and m_ready_x=0, m_data_out_x and m_valid_x hold stable.
REQ-023 Transfer with ptr<N-1: ptr increments and m_data_out_x=mem[ptr+1] next cycle; no bubble.
REQ-024 Result: with m_ready_x held high, N samples go out in N consecutive cycles.
REQ-025 Transfer with ptr=N-1 on the final pass: next cycle m_valid_x=0, busy=0, done=1, state=IDLE, ptr=0.
REQ-026 done is high for exactly one cycle; it is low at all other times.
REQ-027 m_ready_x is ignored when m_valid_x=0.
REQ-028 m_valid_x never deasserts before its transfer completes, except on reset.
REQ-029 A new start is accepted on the cycle where done=1, since the state is IDLE.

Reset
REQ-030 When reset is high at an edge: state=IDLE, ptr=0, m_valid_x=0, m_data_out_x=0, busy=0, done=0, pass counter=0.
REQ-031 Buffer memory is not reset and keeps its contents.
REQ-032 Reset during SEND aborts the vector with no done pulse; m_valid_x is low the next cycle.
REQ-033 reset overrides start and wr_en.

Configuration
REQ-034 With X_STREAM_TX_REPEAT_EN defined: at start, rep_count is captured into a pass counter.
REQ-035 With the macro: the vector is sent rep_count+1 times back-to-back; ptr wraps N-1 -> 0 with no bubble.
REQ-036 With the macro: done pulses only after the final pass; rep_count changes during SEND are ignored.
REQ-037 Without the macro: the rep_count port and pass counter are absent and the vector is sent exactly once.

Structure
REQ-038 Package conv_pkg holds the default T and N, the AW function, and the state enum type.
REQ-039 Buffer is sub-module x_stream_tx_mem: N x T register file, synchronous write, asynchronous read.
REQ-040 The FSM, pointer and output registers live in x_stream_tx.

Verification
REQ-041 Load mem={1,2,..,8}, start, ready=1 -> data 1..8 in cycles 2..9, done at cycle 10.
REQ-042 Same load; ready toggles 1,0,1,0 -> each sample holds while ready=0; order 1..8 with no loss or duplication; one done.
REQ-043 start+wr_en(addr0, 0xAA) in the same cycle, mem[0]=0x11 -> first sample 0x11, mem[0] unchanged afterwards.
REQ-044 reset after the third transfer -> next cycle valid=0 and busy=0, no done; a new start sends from sample 1.
REQ-045 With X_STREAM_TX_REPEAT_EN, rep_count=2, ready=1 -> 24 contiguous samples (1..8 three times), one done.
REQ-046 wr_en during SEND at addr3 with 0xFF -> the vector is unaffected and mem[3] still holds 4.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults, index-width helper and FSM state type for the x_stream_tx block.
package conv_pkg;

    localparam int DEF_T = 8;
    localparam int DEF_N = 8;

    // Index width for an N-entry buffer; never narrower than one bit.
    function automatic int aw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/x_stream_tx_mem.sv
// N x T sample buffer for x_stream_tx: synchronous write port, asynchronous read port.
module x_stream_tx_mem
    import conv_pkg::*;
#(
    parameter  int T  = DEF_T,
    parameter  int N  = DEF_N,
    localparam int AW = aw_f(N)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [T-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [T-1:0]  rd_data
);

    logic [T-1:0] mem_q [N];

    // NOTE: the storage array has no reset branch on purpose; its contents survive
    // a block reset and it maps onto plain register-file cells without reset muxing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/x_stream_tx.sv
// Buffered vector transmitter with a registered valid/ready output stream.
// Optional feature macro X_STREAM_TX_REPEAT_EN adds rep_count: the vector is sent rep_count+1 times.
module x_stream_tx
    import conv_pkg::*;
#(
    parameter  int T  = DEF_T,
    parameter  int N  = DEF_N,
    localparam int AW = aw_f(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [T-1:0]  wr_data,
    input  logic          start,
`ifdef X_STREAM_TX_REPEAT_EN
    input  logic [3:0]    rep_count,
`endif
    output logic          busy,
    output logic          done,
    output logic [T-1:0]  m_data_out_x,
    output logic          m_valid_x,
    input  logic          m_ready_x
);

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [T-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          mem_we;
    logic [AW-1:0] rd_addr;
    logic [T-1:0]  rd_data;
    logic          last_pass;

`ifdef X_STREAM_TX_REPEAT_EN
    logic [3:0] pass_q, pass_d;
    assign last_pass = (pass_q == 4'd0);
`else
    assign last_pass = 1'b1;
`endif

    x_stream_tx_mem #(
        .T (T),
        .N (N)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The sample to present next is either the start of the vector or the one after ptr.
    always_comb begin
        rd_addr = '0;
        if (state_q == SEND && ptr_q != LAST) begin
            rd_addr = ptr_q + AW'(1);
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        mem_we  = 1'b0;
`ifdef X_STREAM_TX_REPEAT_EN
        pass_d  = pass_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    ptr_d   = '0;
                    data_d  = rd_data;
                    valid_d = 1'b1;
`ifdef X_STREAM_TX_REPEAT_EN
                    pass_d  = rep_count;
`endif
                end else if (wr_en && !reset) begin
                    mem_we = 1'b1;
                end
            end
            SEND: begin
                if (valid_q && m_ready_x) begin
                    if (ptr_q != LAST) begin
                        ptr_d  = ptr_q + AW'(1);
                        data_d = rd_data;
                    end else if (!last_pass) begin
                        ptr_d  = '0;
                        data_d = rd_data;
`ifdef X_STREAM_TX_REPEAT_EN
                        pass_d = pass_q - 4'd1;
`endif
                    end else begin
                        state_d = IDLE;
                        ptr_d   = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef X_STREAM_TX_REPEAT_EN
            pass_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef X_STREAM_TX_REPEAT_EN
            pass_q  <= pass_d;
`endif
        end
    end

    assign busy         = (state_q == SEND);
    assign done         = done_q;
    assign m_data_out_x = data_q;
    assign m_valid_x    = valid_q;

endmodule

// File: tb/tb_x_stream_tx.sv
// Self-checking bench for x_stream_tx: directed scenarios plus randomized traffic,
// all compared against a queue-based model of the transmitted stream.
module tb_x_stream_tx;

    localparam int T = 8;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [T-1:0] wr_data;
    logic         start;
    logic         m_ready_x;
    logic         busy;
    logic         done;
    logic [T-1:0] m_data_out_x;
    logic         m_valid_x;
`ifdef X_STREAM_TX_REPEAT_EN
    logic [3:0]   rep_count;
    logic [3:0]   rep_sel;
`endif

    always #5 clk = ~clk;

    x_stream_tx #(
        .T (T),
        .N (N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
`ifdef X_STREAM_TX_REPEAT_EN
        .rep_count    (rep_count),
`endif
        .busy         (busy),
        .done         (done),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: buffer image plus the queue of samples still owed to the stream.
    logic [T-1:0] mdl_mem [N];
    logic [T-1:0] exp_q [$];
    bit           exp_valid = 1'b0;
    bit           exp_done  = 1'b0;
    logic [T-1:0] exp_data  = '0;

    // Drive one cycle of inputs, advance the model across the coming edge, then compare.
    task automatic step(input bit rst, input bit st, input bit we,
                        input logic [2:0] wa, input logic [T-1:0] wd, input bit rdy);
        int npass;
        reset     = rst;
        start     = st;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        m_ready_x = rdy;
`ifdef X_STREAM_TX_REPEAT_EN
        rep_count = rep_sel;
        npass     = int'(rep_sel) + 1;
`else
        npass     = 1;
`endif
        exp_done = 1'b0;
        if (rst) begin
            exp_q.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
        end else if (!exp_valid) begin
            if (st) begin
                for (int p = 0; p < npass; p++)
                    for (int i = 0; i < N; i++) exp_q.push_back(mdl_mem[i]);
                exp_valid = 1'b1;
                exp_data  = exp_q[0];
            end else if (we) begin
                mdl_mem[wa] = wd;
            end
        end else if (rdy) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                exp_valid = 1'b0;
                exp_done  = 1'b1;
            end else begin
                exp_data = exp_q[0];
            end
        end
        @(negedge clk);
        check("valid", 32'(m_valid_x), 32'(exp_valid));
        check("busy",  32'(busy),      32'(exp_valid));
        check("done",  32'(done),      32'(exp_done));
        if (rst) check("data_after_reset", 32'(m_data_out_x), 32'(exp_data));
        else if (exp_valid) check("data", 32'(m_data_out_x), 32'(exp_data));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 3'(i), T'(i + 1), 1'b0);
    endtask

    // mode 0: ready held high; 1: ready toggles 1,0,1,0; 2: random ready plus noise on start/wr_en.
    task automatic run(input int mode);
        int n = 0;
        bit r, st, we;
        while (exp_valid && n < 400) begin
            st = 1'b0;
            we = 1'b0;
            case (mode)
                0:       r = 1'b1;
                1:       r = (n % 2 == 0);
                default: begin
                    r  = 1'($urandom_range(0, 1));
                    st = 1'($urandom_range(0, 1));
                    we = 1'($urandom_range(0, 1));
`ifdef X_STREAM_TX_REPEAT_EN
                    rep_sel = 4'($urandom_range(0, 3));
`endif
                end
            endcase
            step(1'b0, st, we, 3'($urandom_range(0, N - 1)), T'($urandom), r);
            n++;
        end
        check("run_bound", 32'(exp_valid), 32'd0);
    endtask

    initial begin
`ifdef X_STREAM_TX_REPEAT_EN
        rep_sel = 4'd0;
`endif
        for (int i = 0; i < N; i++) mdl_mem[i] = '0;

        // Reset state; the buffer is written afterwards so its reset-free contents are known.
        step(1'b1, 1'b0, 1'b0, 3'd0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, '0, 1'b0);
        idle();
        load_ramp();

        // Single vector with ready high: 1..8 back to back, one done.
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        run(0);
        idle();

        // Ready toggling: each sample holds while stalled.
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        run(1);
        idle();

        // Writes during SEND are ignored; the next vector still carries the ramp.
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 3'd3, 8'hFF, 1'b1);
        step(1'b0, 1'b1, 1'b1, 3'd3, 8'hFF, 1'b0);
        run(0);
        idle();
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        run(0);
        idle();

        // start and wr_en together: start wins, mem[0] keeps 0x11.
        step(1'b0, 1'b0, 1'b1, 3'd0, 8'h11, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd0, 8'hAA, 1'b1);
        run(0);
        idle();
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        run(0);
        idle();
        step(1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);

        // Reset after the third transfer, with start and wr_en also high: abort, no done.
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 3'd0, 8'h55, 1'b1);
        idle();
        idle();
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        run(0);
        idle();

`ifdef X_STREAM_TX_REPEAT_EN
        // Three passes of the ramp with one done; rep_count changes mid-transfer are ignored.
        rep_sel = 4'd2;
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
        rep_sel = 4'd7;
        run(0);
        idle();
        rep_sel = 4'd0;
`endif

        // Random traffic, including a restart on the done cycle.
        for (int it = 0; it < 20; it++) begin
            int nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                step(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, N - 1)), T'($urandom), 1'b0);
`ifdef X_STREAM_TX_REPEAT_EN
            rep_sel = 4'($urandom_range(0, 2));
`endif
            step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'($urandom_range(0, 1)));
            run(2);
            if ($urandom_range(0, 1) == 1) begin
                step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'($urandom_range(0, 1)));
                run(2);
            end
            idle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
